turbosound: RTL and testbench

Sequencer and chip-select arbiter for a pair of AY-3-8912 PSGs sharing the CPU bus. It decodes the #FFFD/#BFFD port accesses and owns a chip-select register, with writes of #FE/#FF to #FFFD choosing the active chip. It drives per-chip BC1/BDIR strobes held for a guaranteed minimum width, and requests CPU wait states when a turbo-speed I/O cycle would be shorter than that width. It also generates the shared PSG clock from the 3.5 MHz enable.

---
 rtl/turbosound_if.sv | 11 +
 rtl/turbosound.sv | 140 ++++++++++++++
 tb/tb_turbosound.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turbosound_if.sv
// CPU I/O bus as seen by the TurboSound sequencer: address, strobes and write data.
interface turbosound_if;
  logic [15:0] a;
  logic        iorq;
  logic        m1;
  logic        wr;
  logic [7:0]  d;

  modport master (output a, iorq, m1, wr, d);
  modport slave  (input  a, iorq, m1, wr, d);
endinterface

// File: rtl/turbosound.sv
// Dual AY-3-8912 sequencer: #FFFD/#BFFD decode, chip select, min-width BC1/BDIR strobes, PSG clock.
// Optional macro TURBOSOUND_EN enables the second chip and the #FE/#FF select writes.
module turbosound #(
  parameter int unsigned MIN_STROBE = 8
) (
  input  logic               clk28,
  input  logic               rst_n,
  input  logic               en,
  turbosound_if.slave        bus,
  input  logic               ck35,
  output logic               ay_clk,
  output logic [1:0]         ay_bc1,
  output logic [1:0]         ay_bdir,
  output logic               ay_sel,
  output logic               d_out_active,
  output logic               wait_req
);

  localparam int unsigned    CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_STROBE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_SWALLOW = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              sel_d;
  logic [1:0]        bc1_d, bdir_d;
  logic              wait_d, dout_d;

  logic              hit_c, port_fffd_c, port_bffd_c, access_c;
  logic [1:0]        chip_mask_c;
  logic              unused_bits;

  // Port decode
  assign hit_c       = en & bus.a[15] & ~bus.a[1] & bus.iorq & ~bus.m1;
  assign port_fffd_c = hit_c & bus.a[14];
  assign port_bffd_c = hit_c & ~bus.a[14];
  assign access_c    = port_fffd_c | (port_bffd_c & bus.wr);
  assign chip_mask_c = ay_sel ? 2'b10 : 2'b01;
  assign unused_bits = ^{bus.a[13:2], bus.a[0], bus.d};

`ifdef TURBOSOUND_EN
  logic sel_wr_c;
  assign sel_wr_c = port_fffd_c & bus.wr & (bus.d[7:1] == 7'h7F);
`endif

  // Next state, counter and output pattern
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bc1_d   = ay_bc1;
    bdir_d  = ay_bdir;
`ifdef TURBOSOUND_EN
    sel_d   = ay_sel;
`else
    sel_d   = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        bc1_d  = 2'b00;
        bdir_d = 2'b00;
        cnt_d  = '0;
`ifdef TURBOSOUND_EN
        if (sel_wr_c) begin
          sel_d   = ~bus.d[0];
          state_d = ST_SWALLOW;
        end else
`endif
        if (access_c) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(1);
          bc1_d   = port_fffd_c ? chip_mask_c : 2'b00;
          bdir_d  = bus.wr ? chip_mask_c : 2'b00;
        end
      end
      ST_STROBE: begin
        if (cnt < CNT_MAX) cnt_d = cnt + CNT_W'(1);
        // Strobe holds for the full count, then until the CPU cycle ends
        if ((cnt == CNT_MAX) && !hit_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          bc1_d   = 2'b00;
          bdir_d  = 2'b00;
        end
      end
      ST_SWALLOW: begin
        if (!hit_c) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bc1_d   = 2'b00;
        bdir_d  = 2'b00;
      end
    endcase

    // Disabling the PSGs aborts whatever is in flight
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bc1_d   = 2'b00;
      bdir_d  = 2'b00;
    end

    wait_d = (state_d == ST_STROBE) && (cnt_d < CNT_MAX);
    dout_d = (state_d == ST_STROBE) && (|bc1_d) && !(|bdir_d);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ay_sel       <= 1'b0;
      ay_bc1       <= 2'b00;
      ay_bdir      <= 2'b00;
      wait_req     <= 1'b0;
      d_out_active <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      ay_sel       <= sel_d;
      ay_bc1       <= bc1_d;
      ay_bdir      <= bdir_d;
      wait_req     <= wait_d;
      d_out_active <= dout_d;
    end
  end

  // PSG clock: divide the 3.5 MHz enable by two, independent of en
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)    ay_clk <= 1'b0;
    else if (ck35) ay_clk <= ~ay_clk;
  end

endmodule

// File: tb/tb_turbosound.sv
// Self-checking bench for turbosound: randomized bus accesses against a cycle-window reference model.
module tb_turbosound;
  localparam int unsigned MIN = 8;

  typedef enum int {C_NONE, C_LATCH, C_WRITE, C_READ, C_SELECT} cls_e;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       ck35  = 1'b0;
  logic       ay_clk, ay_sel, d_out_active, wait_req;
  logic [1:0] ay_bc1, ay_bdir;

  int   n_cmp = 0;
  int   n_err = 0;
  logic mdl_sel = 1'b0;
  logic [6:0] obs_q[$];
  logic [6:0] exp_q[$];

  turbosound_if bus();

  turbosound #(.MIN_STROBE(MIN)) dut (
    .clk28(clk28), .rst_n(rst_n), .en(en), .bus(bus), .ck35(ck35),
    .ay_clk(ay_clk), .ay_bc1(ay_bc1), .ay_bdir(ay_bdir), .ay_sel(ay_sel),
    .d_out_active(d_out_active), .wait_req(wait_req)
  );

  always #18 clk28 = ~clk28;

  task automatic bus_idle();
    bus.a = 16'h0000; bus.iorq = 1'b0; bus.m1 = 1'b0; bus.wr = 1'b0; bus.d = 8'h00;
  endtask

  // What kind of cycle the CPU is running, from the port map alone
  function automatic cls_e classify(input logic [15:0] a, input logic w, input logic [7:0] d,
                                    input logic m1v);
    logic [6:0] hi;
    hi = d[7:1];
    if (!(a[15] && !a[1] && !m1v)) return C_NONE;
    if (a[14]) begin
      if (!w) return C_READ;
`ifdef TURBOSOUND_EN
      if (hi == 7'h7F) return C_SELECT;
`endif
      return C_LATCH;
    end
    return w ? C_WRITE : C_NONE;
  endfunction

  // Expected {bc1, bdir, sel, wait, dout} k cycles after the access was put on the bus.
  // The strobe lives for max(MIN, hold) cycles unless en is pulled after cycle en_off.
  function automatic logic [6:0] exp_vec(input cls_e c, input logic sel_now, input int h,
                                         input int en_off, input int k);
    logic act;
    logic [1:0] m, b1, bd;
    int width;
    width = (h > int'(MIN)) ? h : int'(MIN);
    act = (c == C_LATCH || c == C_WRITE || c == C_READ) && (k <= width) && (k <= en_off);
    m   = sel_now ? 2'b10 : 2'b01;
    b1  = (act && c != C_WRITE) ? m : 2'b00;
    bd  = (act && c != C_READ)  ? m : 2'b00;
    return {b1, bd, sel_now, act && (k < int'(MIN)), act && (c == C_READ)};
  endfunction

  // Run one I/O cycle held for h clocks, recording outputs and model expectations each cycle
  task automatic do_access(input logic [15:0] addr, input logic w, input logic [7:0] dat,
                           input logic m1v, input int h, input int en_off);
    cls_e c;
    logic sel_now;
    int span;
    c = classify(addr, w, dat, m1v);
    sel_now = (c == C_SELECT) ? ~dat[0] : mdl_sel;
    span = ((h > int'(MIN)) ? h : int'(MIN)) + 2;
    obs_q.delete();
    exp_q.delete();
    @(posedge clk28); #1;
    bus.a = addr; bus.wr = w; bus.d = dat; bus.m1 = m1v; bus.iorq = 1'b1;
    for (int k = 1; k <= span; k++) begin
      @(posedge clk28); #1;
      if (k == h) bus.iorq = 1'b0;
      if (k == en_off) en = 1'b0;
      @(negedge clk28);
      obs_q.push_back({ay_bc1, ay_bdir, ay_sel, wait_req, d_out_active});
      exp_q.push_back(exp_vec(c, sel_now, h, en_off, k));
    end
    en = 1'b1;
    bus_idle();
    mdl_sel = sel_now;
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 1'b0;
    en = 1'b0;
    repeat (3) @(posedge clk28);
    #1;
    n_cmp++;
    if ({ay_clk, ay_bc1, ay_bdir, ay_sel, wait_req, d_out_active} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_held: got %b want 00000000",
               {ay_clk, ay_bc1, ay_bdir, ay_sel, wait_req, d_out_active});
    end
    @(negedge clk28);
    rst_n = 1'b1;
    en = 1'b1;
    mdl_sel = 1'b0;
    @(posedge clk28); @(negedge clk28);
    n_cmp++;
    if ({ay_clk, ay_bc1, ay_bdir, ay_sel, wait_req, d_out_active} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_release: got %b want 00000000",
               {ay_clk, ay_bc1, ay_bdir, ay_sel, wait_req, d_out_active});
    end
  endtask

  task automatic test_addr_latch();
    int width;
    do_access(16'hFFFD, 1'b1, 8'h05, 1'b0, 2, 1000);
    width = 0;
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL addr_latch cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
      if (obs_q[i][6:3] == 4'b0101) width++;
    end
    n_cmp++;
    if (width != int'(MIN)) begin
      n_err++;
      $display("FAIL addr_latch_width: got %0d want %0d", width, MIN);
    end
  endtask

  task automatic test_select_then_write();
    do_access(16'hFFFD, 1'b1, 8'hFE, 1'b0, 2, 1000);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL select_fe cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    do_access(16'hBFFD, 1'b1, 8'h3C, 1'b0, 3, 1000);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL data_write cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_read();
    do_access(16'hFFFD, 1'b0, 8'h00, 1'b0, 4, 1000);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reg_read cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_turbo_and_long();
    int hold[2] = '{2, 20};
    int width;
    for (int t = 0; t < 2; t++) begin
      do_access(16'hBFFD, 1'b1, 8'hA5, 1'b0, hold[t], 1000);
      width = 0;
      foreach (obs_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL hold%0d cyc%0d: got %b want %b", hold[t], i + 1, obs_q[i], exp_q[i]);
        end
        if (obs_q[i][4:3] != 2'b00) width++;
      end
      n_cmp++;
      if (width != ((t == 0) ? int'(MIN) : 20)) begin
        n_err++;
        $display("FAIL hold%0d_width: got %0d want %0d", hold[t], width, (t == 0) ? int'(MIN) : 20);
      end
    end
  endtask

  task automatic test_en_abort();
    do_access(16'hBFFD, 1'b1, 8'h11, 1'b0, 12, 3);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL en_abort cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_access(16'hFFFD, 1'b1, 8'h07, 1'b0, 1, 1000);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_first cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    do_access(16'hBFFD, 1'b1, 8'h99, 1'b0, 1, 1000);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_second cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    logic        w, m1v;
    int          h, eo;
    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom);
      a[15] = ($urandom_range(0, 4) != 0);
      a[1]  = ($urandom_range(0, 4) == 0);
      m1v   = ($urandom_range(0, 9) == 0);
      w     = 1'($urandom);
      d     = ($urandom_range(0, 3) == 0) ? {7'h7F, 1'($urandom)} : 8'($urandom);
      h     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(9, 20)) : int'($urandom_range(1, 8));
      eo    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 1000;
      do_access(a, w, d, m1v, h, eo);
      foreach (obs_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rand%0d a=%h wr=%b d=%h h=%0d eo=%0d cyc%0d: got %b want %b",
                   n, a, w, d, h, eo, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ay_clk();
    logic mdl_clk, prev_ck;
    mdl_clk = 1'b0;
    prev_ck = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 41; k++) begin
      @(posedge clk28);
      if (prev_ck) mdl_clk = ~mdl_clk;
      #1;
      ck35 = (k < 40) ? 1'($urandom) : 1'b0;
      prev_ck = ck35;
      @(negedge clk28);
      n_cmp++;
      if (ay_clk !== mdl_clk) begin
        n_err++;
        $display("FAIL ay_clk cyc%0d: got %b want %b", k, ay_clk, mdl_clk);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [1:0] m;
    do_access(16'hFFFD, 1'b1, 8'hFE, 1'b0, 1, 1000);
    m = mdl_sel ? 2'b10 : 2'b01;
    @(posedge clk28); #1;
    bus.a = 16'hBFFD; bus.wr = 1'b1; bus.d = 8'h42; bus.iorq = 1'b1;
    repeat (3) @(posedge clk28);
    #1;
    n_cmp++;
    if ({ay_bc1, ay_bdir, ay_sel} !== {2'b00, m, mdl_sel}) begin
      n_err++;
      $display("FAIL pre_reset_strobe: got %b want %b", {ay_bc1, ay_bdir, ay_sel}, {2'b00, m, mdl_sel});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ay_clk, ay_bc1, ay_bdir, ay_sel, wait_req, d_out_active} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid: got %b want 00000000",
               {ay_clk, ay_bc1, ay_bdir, ay_sel, wait_req, d_out_active});
    end
    mdl_sel = 1'b0;
    bus_idle();
    @(negedge clk28);
    rst_n = 1'b1;
    do_access(16'hBFFD, 1'b1, 8'h24, 1'b0, 2, 1000);
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL after_reset cyc%0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_latch();
    test_select_then_write();
    test_read();
    test_turbo_and_long();
    test_en_abort();
    test_back_to_back();
    test_random();
    test_ay_clk();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
